// File: rtl/xsim_portal_mux.sv
// Portal bridge: demultiplexes host request beats into per-portal FIFOs by portal id and
// round-robin arbitrates indication portals into one registered host beat stage.
module xsim_portal_mux #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_IND    = 2,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      req_beat_valid,
  input  logic [ID_W-1:0]           req_beat_portal,
  input  logic [DATA_W-1:0]         req_beat_data,
  output logic                      req_beat_ready,
  input  logic [NUM_REQ*ID_W-1:0]   req_id,
  output logic [NUM_REQ*DATA_W-1:0] req_enq_v,
  output logic [NUM_REQ-1:0]        en_req_enq,
  input  logic [NUM_REQ-1:0]        rdy_req_enq,
  input  logic [NUM_IND*ID_W-1:0]   ind_id,
  input  logic [NUM_IND*DATA_W-1:0] ind_first,
  input  logic [NUM_IND-1:0]        rdy_ind_first,
  input  logic [NUM_IND-1:0]        rdy_ind_deq,
  output logic [NUM_IND-1:0]        en_ind_deq,
  output logic                      ind_beat_valid,
  output logic [ID_W-1:0]           ind_beat_portal,
  output logic [DATA_W-1:0]         ind_beat_data,
  input  logic                      ind_beat_ready,
  output logic [CNT_W-1:0]          drop_count
);

  // Handshakes: a beat transfers on a clock edge where valid & ready are both high;
  // en_* strobes are the transfer itself (the portal side already showed ready).

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int RI_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int II_W = (NUM_IND > 1) ? $clog2(NUM_IND) : 1;

  logic                match_any;
  logic [RI_W-1:0]     match_idx;
  logic [NUM_REQ-1:0]  fifo_full;
  logic [NUM_REQ-1:0]  fifo_empty;
  logic [NUM_REQ-1:0]  fifo_push;
  logic                req_accept;

  // Descending scan so the lowest matching channel is the one left standing.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_id[i*ID_W +: ID_W] == req_beat_portal) begin
        match_any = 1'b1;
        match_idx = RI_W'(i);
      end
    end
  end

  assign req_beat_ready = match_any ? !fifo_full[match_idx] : 1'b1;
  assign req_accept     = req_beat_valid & req_beat_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    assign fifo_empty[i] = (wr_ptr == rd_ptr);
    assign fifo_full[i]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_push[i]  = req_accept & match_any & (match_idx == RI_W'(i));
    assign en_req_enq[i] = RST_N & !fifo_empty[i] & rdy_req_enq[i];
    assign req_enq_v[i*DATA_W +: DATA_W] = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (fifo_push[i])  wr_ptr <= wr_ptr + 1'b1;
        if (en_req_enq[i]) rd_ptr <= rd_ptr + 1'b1;
      end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge CLK) begin
      if (fifo_push[i]) mem[wr_ptr[AW-1:0]] <= req_beat_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drop_count <= '0;
    end else if (req_accept && !match_any && (drop_count != {CNT_W{1'b1}})) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  logic [NUM_IND-1:0] elig;
  logic               grant_any;
  logic [II_W-1:0]    grant_idx;
  logic [II_W-1:0]    cand;
  logic [II_W-1:0]    rr_ptr;
  logic [II_W-1:0]    rr_next;
  logic               load;
  logic [ID_W-1:0]    sel_id;
  logic [DATA_W-1:0]  sel_data;

  assign elig = rdy_ind_first & rdy_ind_deq;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_IND; k++) begin
      cand = II_W'((int'(rr_ptr) + k) % NUM_IND);
      if (!grant_any && elig[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    for (int j = 0; j < NUM_IND; j++) begin
      if (grant_idx == II_W'(j)) begin
        sel_id   = ind_id[j*ID_W +: ID_W];
        sel_data = ind_first[j*DATA_W +: DATA_W];
      end
    end
  end

  // RST_N gates the strobe so nothing is dequeued while reset is held.
  assign load    = RST_N & (!ind_beat_valid | ind_beat_ready) & grant_any;
  assign rr_next = (grant_idx == II_W'(NUM_IND - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    en_ind_deq = '0;
    if (load) en_ind_deq[grant_idx] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ind_beat_valid  <= 1'b0;
      ind_beat_portal <= '0;
      ind_beat_data   <= '0;
      rr_ptr          <= '0;
    end else if (load) begin
      ind_beat_valid  <= 1'b1;
      ind_beat_portal <= sel_id;
      ind_beat_data   <= sel_data;
      rr_ptr          <= rr_next;
    end else if (ind_beat_valid && ind_beat_ready) begin
      ind_beat_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xsim_portal_mux.sv
// Bench for xsim_portal_mux: directed scenarios plus randomized traffic checked against
// queue-based request routing and a round-robin indication model.
module tb_xsim_portal_mux;

  localparam int NUM_REQ    = 2;
  localparam int NUM_IND    = 2;
  localparam int DATA_W     = 32;
  localparam int ID_W       = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                      CLK;
  logic                      RST_N;
  logic                      req_beat_valid;
  logic [ID_W-1:0]           req_beat_portal;
  logic [DATA_W-1:0]         req_beat_data;
  logic                      req_beat_ready;
  logic [NUM_REQ*ID_W-1:0]   req_id;
  logic [NUM_REQ*DATA_W-1:0] req_enq_v;
  logic [NUM_REQ-1:0]        en_req_enq;
  logic [NUM_REQ-1:0]        rdy_req_enq;
  logic [NUM_IND*ID_W-1:0]   ind_id;
  logic [NUM_IND*DATA_W-1:0] ind_first;
  logic [NUM_IND-1:0]        rdy_ind_first;
  logic [NUM_IND-1:0]        rdy_ind_deq;
  logic [NUM_IND-1:0]        en_ind_deq;
  logic                      ind_beat_valid;
  logic [ID_W-1:0]           ind_beat_portal;
  logic [DATA_W-1:0]         ind_beat_data;
  logic                      ind_beat_ready;
  logic [CNT_W-1:0]          drop_count;

  xsim_portal_mux #(
    .NUM_REQ(NUM_REQ), .NUM_IND(NUM_IND), .DATA_W(DATA_W), .ID_W(ID_W),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_beat_valid(req_beat_valid), .req_beat_portal(req_beat_portal),
    .req_beat_data(req_beat_data), .req_beat_ready(req_beat_ready),
    .req_id(req_id), .req_enq_v(req_enq_v), .en_req_enq(en_req_enq),
    .rdy_req_enq(rdy_req_enq),
    .ind_id(ind_id), .ind_first(ind_first), .rdy_ind_first(rdy_ind_first),
    .rdy_ind_deq(rdy_ind_deq), .en_ind_deq(en_ind_deq),
    .ind_beat_valid(ind_beat_valid), .ind_beat_portal(ind_beat_portal),
    .ind_beat_data(ind_beat_data), .ind_beat_ready(ind_beat_ready),
    .drop_count(drop_count)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] exp_q [NUM_REQ][$];
  int                exp_drops;
  int                m_rr;
  bit                m_v;
  logic [ID_W-1:0]   m_portal;
  logic [DATA_W-1:0] m_data;

  // Expectations for the current cycle, derived from model state and driven inputs
  int                 e_match;
  bit                 e_ready;
  logic [NUM_REQ-1:0] e_en_req;
  logic [NUM_IND-1:0] e_en_ind;
  int                 e_grant;

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
    exp_drops = 0;
    m_rr      = 0;
    m_v       = 1'b0;
    m_portal  = '0;
    m_data    = '0;
  endtask

  task automatic predict();
    int m_idx;
    int g;
    m_idx = -1;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_id[i*ID_W +: ID_W] == req_beat_portal) m_idx = i;
    e_match = m_idx;
    e_ready = (m_idx < 0) ? 1'b1 : (exp_q[m_idx].size() < FIFO_DEPTH);
    for (int i = 0; i < NUM_REQ; i++)
      e_en_req[i] = (exp_q[i].size() > 0) && rdy_req_enq[i];
    g = -1;
    if (!m_v || ind_beat_ready) begin
      for (int k = 0; k < NUM_IND; k++) begin
        int c;
        c = (m_rr + k) % NUM_IND;
        if (g < 0 && rdy_ind_first[c] && rdy_ind_deq[c]) g = c;
      end
    end
    e_grant  = g;
    e_en_ind = '0;
    if (g >= 0) e_en_ind[g] = 1'b1;
  endtask

  // Advance one clock and apply the same transfers to the model
  task automatic tick();
    bit acc;
    predict();
    acc = req_beat_valid && e_ready;
    @(posedge CLK);
    for (int i = 0; i < NUM_REQ; i++)
      if (e_en_req[i]) void'(exp_q[i].pop_front());
    if (acc) begin
      if (e_match >= 0) exp_q[e_match].push_back(req_beat_data);
      else if (exp_drops < CNT_MAX) exp_drops++;
    end
    if (e_grant >= 0) begin
      m_v      = 1'b1;
      m_portal = ind_id[e_grant*ID_W +: ID_W];
      m_data   = ind_first[e_grant*DATA_W +: DATA_W];
      m_rr     = (e_grant + 1) % NUM_IND;
    end else if (m_v && ind_beat_ready) begin
      m_v = 1'b0;
    end
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    req_beat_valid  = 1'b0;
    req_beat_portal = '0;
    req_beat_data   = '0;
    rdy_req_enq     = '0;
    rdy_ind_first   = '0;
    rdy_ind_deq     = '0;
    ind_beat_ready  = 1'b0;
  endtask

  task automatic test_reset();
    RST_N           = 1'b0;
    req_id          = {32'h5, 32'h3};
    ind_id          = {32'h22, 32'h11};
    ind_first       = {32'hBEEF0001, 32'hBEEF0000};
    req_beat_valid  = 1'b1;
    req_beat_portal = 32'h77;
    req_beat_data   = 32'h1234;
    rdy_req_enq     = '1;
    rdy_ind_first   = '1;
    rdy_ind_deq     = '1;
    ind_beat_ready  = 1'b1;
    #3;
    checks++; if (en_req_enq !== '0) begin errors++; $display("FAIL reset_en_req act=%b exp=0", en_req_enq); end
    checks++; if (en_ind_deq !== '0) begin errors++; $display("FAIL reset_en_ind act=%b exp=0", en_ind_deq); end
    checks++; if (ind_beat_valid !== 1'b0) begin errors++; $display("FAIL reset_ind_valid act=%b exp=0", ind_beat_valid); end
    checks++; if (ind_beat_portal !== '0 || ind_beat_data !== '0) begin errors++; $display("FAIL reset_ind_beat act=%h/%h exp=0/0", ind_beat_portal, ind_beat_data); end
    checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop act=%0d exp=0", drop_count); end
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic test_routing();
    req_beat_valid  = 1'b1;
    req_beat_portal = 32'h5;
    req_beat_data   = 32'hA5A5A5A5;
    rdy_req_enq     = 2'b11;
    #1;
    checks++; if (req_beat_ready !== 1'b1) begin errors++; $display("FAIL route_ready act=%b exp=1", req_beat_ready); end
    checks++; if (en_req_enq !== 2'b00) begin errors++; $display("FAIL route_no_early act=%b exp=00", en_req_enq); end
    tick();
    req_beat_valid = 1'b0;
    #1;
    checks++; if (en_req_enq !== 2'b10) begin errors++; $display("FAIL route_strobe act=%b exp=10", en_req_enq); end
    checks++; if (req_enq_v[63:32] !== 32'hA5A5A5A5) begin errors++; $display("FAIL route_data act=%h exp=a5a5a5a5", req_enq_v[63:32]); end
    tick();
    #1;
    checks++; if (en_req_enq !== 2'b00) begin errors++; $display("FAIL route_drained act=%b exp=00", en_req_enq); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d [5];
    int popped;
    for (int k = 0; k < 5; k++) d[k] = $urandom;
    rdy_req_enq = 2'b00;
    for (int k = 0; k < 5; k++) begin
      req_beat_valid  = 1'b1;
      req_beat_portal = 32'h3;
      req_beat_data   = d[k];
      #1;
      checks++; if (req_beat_ready !== (k < 4)) begin errors++; $display("FAIL bp_fill_ready k=%0d act=%b exp=%b", k, req_beat_ready, (k < 4)); end
      if (k < 4) tick();
    end
    rdy_req_enq = 2'b01;
    popped = 0;
    for (int c = 0; c < 7; c++) begin
      bit acc;
      predict();
      #1;
      checks++; if (req_beat_ready !== e_ready) begin errors++; $display("FAIL bp_ready c=%0d act=%b exp=%b", c, req_beat_ready, e_ready); end
      checks++; if (en_req_enq !== e_en_req) begin errors++; $display("FAIL bp_en c=%0d act=%b exp=%b", c, en_req_enq, e_en_req); end
      if (en_req_enq[0] && popped < 5) begin
        checks++; if (req_enq_v[31:0] !== d[popped]) begin errors++; $display("FAIL bp_order c=%0d act=%h exp=%h", c, req_enq_v[31:0], d[popped]); end
        popped++;
      end
      acc = req_beat_valid && e_ready;
      tick();
      if (acc) req_beat_valid = 1'b0;
    end
    checks++; if (popped != 5) begin errors++; $display("FAIL bp_count act=%0d exp=5", popped); end
  endtask

  task automatic test_drop();
    rdy_req_enq     = 2'b11;
    req_beat_portal = 32'h77;
    for (int k = 0; k < 3; k++) begin
      req_beat_valid = 1'b1;
      req_beat_data  = $urandom;
      #1;
      checks++; if (req_beat_ready !== 1'b1) begin errors++; $display("FAIL drop_ready k=%0d act=%b exp=1", k, req_beat_ready); end
      checks++; if (en_req_enq !== 2'b00) begin errors++; $display("FAIL drop_en k=%0d act=%b exp=00", k, en_req_enq); end
      tick();
    end
    req_beat_valid = 1'b0;
    #1;
    checks++; if (drop_count !== 4'd3) begin errors++; $display("FAIL drop_count act=%0d exp=3", drop_count); end
    req_beat_valid = 1'b1;
    for (int k = 0; k < CNT_MAX; k++) tick();
    req_beat_valid = 1'b0;
    #1;
    checks++; if (drop_count !== 4'hF || exp_drops != CNT_MAX) begin errors++; $display("FAIL drop_saturate act=%0d exp=%0d", drop_count, CNT_MAX); end
  endtask

  task automatic test_round_robin();
    rdy_ind_first  = 2'b11;
    rdy_ind_deq    = 2'b11;
    ind_beat_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      ind_first = {$urandom, $urandom};
      predict();
      #1;
      checks++; if (en_ind_deq !== (2'b01 << (n % 2))) begin errors++; $display("FAIL rr_grant n=%0d act=%b exp=%b", n, en_ind_deq, 2'b01 << (n % 2)); end
      checks++; if (ind_beat_valid !== (n > 0)) begin errors++; $display("FAIL rr_valid n=%0d act=%b exp=%b", n, ind_beat_valid, (n > 0)); end
      if (n > 0) begin
        checks++; if (ind_beat_portal !== m_portal || ind_beat_data !== m_data) begin errors++; $display("FAIL rr_beat n=%0d act=%h/%h exp=%h/%h", n, ind_beat_portal, ind_beat_data, m_portal, m_data); end
        checks++; if (ind_beat_portal !== ((n % 2) ? 32'h11 : 32'h22)) begin errors++; $display("FAIL rr_portal n=%0d act=%h", n, ind_beat_portal); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [ID_W-1:0]   held_portal;
    logic [DATA_W-1:0] held_data;
    ind_beat_ready = 1'b0;
    held_portal    = m_portal;
    held_data      = m_data;
    for (int n = 0; n < 5; n++) begin
      ind_first = {$urandom, $urandom};
      #1;
      checks++; if (en_ind_deq !== 2'b00) begin errors++; $display("FAIL stall_en n=%0d act=%b exp=00", n, en_ind_deq); end
      checks++; if (ind_beat_valid !== 1'b1 || ind_beat_portal !== held_portal || ind_beat_data !== held_data) begin
        errors++; $display("FAIL stall_hold n=%0d act=%b/%h/%h exp=1/%h/%h", n, ind_beat_valid, ind_beat_portal, ind_beat_data, held_portal, held_data);
      end
      tick();
    end
    ind_beat_ready = 1'b1;
    predict();
    #1;
    checks++; if (en_ind_deq !== e_en_ind || e_grant != m_rr) begin errors++; $display("FAIL stall_release act=%b exp=%b", en_ind_deq, e_en_ind); end
    tick();
    #1;
    checks++; if (ind_beat_portal !== m_portal || ind_beat_data !== m_data) begin errors++; $display("FAIL stall_next act=%h/%h exp=%h/%h", ind_beat_portal, ind_beat_data, m_portal, m_data); end
  endtask

  task automatic drive_random();
    int sel;
    sel             = $urandom_range(0, 3);
    req_beat_valid  = $urandom_range(0, 3) != 0;
    req_beat_portal = (sel == 0) ? 32'h3 : (sel == 1) ? 32'h5 : (sel == 2) ? 32'h77 : $urandom;
    req_beat_data   = $urandom;
    rdy_req_enq     = NUM_REQ'($urandom);
    rdy_ind_first   = NUM_IND'($urandom);
    rdy_ind_deq     = NUM_IND'($urandom | $urandom);
    ind_beat_ready  = $urandom_range(0, 2) != 0;
    ind_first       = {$urandom, $urandom};
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_random();
      predict();
      #1;
      checks++; if (req_beat_ready !== e_ready) begin errors++; $display("FAIL rnd_ready n=%0d act=%b exp=%b", n, req_beat_ready, e_ready); end
      checks++; if (en_req_enq !== e_en_req) begin errors++; $display("FAIL rnd_en_req n=%0d act=%b exp=%b", n, en_req_enq, e_en_req); end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (exp_q[i].size() > 0) begin
          checks++; if (req_enq_v[i*DATA_W +: DATA_W] !== exp_q[i][0]) begin errors++; $display("FAIL rnd_head ch=%0d n=%0d act=%h exp=%h", i, n, req_enq_v[i*DATA_W +: DATA_W], exp_q[i][0]); end
        end
      end
      checks++; if (en_ind_deq !== e_en_ind) begin errors++; $display("FAIL rnd_en_ind n=%0d act=%b exp=%b", n, en_ind_deq, e_en_ind); end
      checks++; if (ind_beat_valid !== m_v) begin errors++; $display("FAIL rnd_ind_valid n=%0d act=%b exp=%b", n, ind_beat_valid, m_v); end
      checks++; if (ind_beat_portal !== m_portal || ind_beat_data !== m_data) begin errors++; $display("FAIL rnd_ind_beat n=%0d act=%h/%h exp=%h/%h", n, ind_beat_portal, ind_beat_data, m_portal, m_data); end
      checks++; if (drop_count !== exp_drops[CNT_W-1:0]) begin errors++; $display("FAIL rnd_drop n=%0d act=%0d exp=%0d", n, drop_count, exp_drops); end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    for (int n = 0; n < 12; n++) begin
      drive_random();
      rdy_req_enq = '0;
      tick();
    end
    drive_random();
    rdy_req_enq   = '1;
    rdy_ind_first = '1;
    rdy_ind_deq   = '1;
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (en_req_enq !== '0 || en_ind_deq !== '0) begin errors++; $display("FAIL midrst_strobes act=%b/%b exp=0/0", en_req_enq, en_ind_deq); end
    checks++; if (ind_beat_valid !== 1'b0 || ind_beat_portal !== '0 || ind_beat_data !== '0) begin errors++; $display("FAIL midrst_ind act=%b/%h/%h exp=0/0/0", ind_beat_valid, ind_beat_portal, ind_beat_data); end
    checks++; if (drop_count !== '0) begin errors++; $display("FAIL midrst_drop act=%0d exp=0", drop_count); end
    @(negedge CLK);
    idle_inputs();
    rdy_req_enq = '1;
    RST_N = 1'b1;
    model_reset();
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (en_req_enq !== 2'b00) begin errors++; $display("FAIL midrst_stale n=%0d act=%b exp=00", n, en_req_enq); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_drop();
    test_round_robin();
    test_stall();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
